seq_scheduler: RTL and testbench
================================

Name: seq_scheduler

Overview:
- Programmable sequencer for the 10-phase atomic-clock timing sequence.
- Holds a per-phase duration table writable over a simple config port, and runs the sequence for N repetitions or continuously under start/abort control.
- Reports the current phase as binary and one-hot, with entry strobes and completion pulses.
- Sits between the host/config logic and the per-phase datapath drivers.

Parameters:
- NBITS, 27, width of each duration entry and of the phase counter.
- NPH, 10, number of phases (table depth); the phase index is 4 bits.
- CBITS, 16, width of the repeat count and cycle counter.
- D0..D9, 20000/50000/60000000/250000/30000000/630000/1840000/1890000/950000/1200000, reset-default duration of each phase in clk cycles (sum 96830000).

Ports:
- clk  in  1  system clock, all logic on rising edge.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  request to begin a run (sampled in IDLE only).
- abort  in  1  stop the run; the scheduler returns to IDLE.
- n_cycles  in  CBITS  repeat count, latched at start; 0 = run forever.
- cfg_we  in  1  duration-table write strobe.
- cfg_addr  in  4  table index 0..9.
- cfg_data  in  NBITS  duration in cycles; 0 = skip the phase.
- busy  out  1  high while in RUN.
- phase  out  4  current phase index; 0 when idle.
- phase_onehot  out  NPH  bit k set while in phase k; all-zero when idle.
- phase_strobe  out  1  one-cycle pulse on the first cycle of every phase entered.
- cycle_done  out  1  one-cycle pulse on the last cycle of each full sequence pass.
- done  out  1  one-cycle pulse when a finite run completes normally.
- aborted  out  1  one-cycle pulse when abort ends a run.
- cycle_count  out  CBITS  completed passes in the current or last run.
- cfg_err  out  1  one-cycle pulse on a rejected config write.

Behaviour:
- Reset (reset=0, async):
  - Duration table is loaded with D0..D9.
  - State goes to IDLE.
  - All outputs are 0, including cycle_count.
- States:
  - IDLE: busy=0, phase=0, phase_onehot=0.
  - RUN: a down-counter runs and phase indexes the table.
- Start condition: start=1 in IDLE, abort=0, and at least one table entry nonzero.
  - Next cycle: RUN, phase = first nonzero index, counter = D[phase]-1, phase_strobe=1.
  - Also on that cycle: cycle_count cleared, n_cycles latched.
  - Latency from start to first strobe is exactly 1 cycle.
- Start with an all-zero table: no state change; cfg_err pulses 1 cycle.
- Start while in RUN is ignored.
- Phase k occupies exactly D[k] cycles, counting the strobe cycle.
- Advance: when the counter reaches 0, the next cycle enters the next nonzero index above phase and reloads the counter. phase_strobe pulses on that cycle.
- Zero-duration entries are skipped and never appear on phase or phase_onehot.
- End of pass (counter reaches 0 in the last nonzero phase):
  - cycle_done=1 on that cycle.
  - cycle_count increments, saturating at all-ones.
  - If n_cycles≠0 and the new count equals n_cycles: next cycle IDLE, done=1.
  - Otherwise: wrap to the first nonzero phase with phase_strobe, with no gap cycle.
- abort=1 in RUN:
  - Next cycle IDLE with aborted=1.
  - done is not asserted; cycle_count holds its value.
  - abort has priority over an end-of-pass on the same cycle, so done is not pulsed.
- abort in IDLE has no effect. start and abort together in IDLE: abort wins, stay IDLE.
- Config writes:
  - Accepted only in IDLE with cfg_addr≤9; the table updates on the next edge.
  - Writes in RUN or with cfg_addr≥10 are dropped, and cfg_err pulses on the following cycle.
  - Table changes never affect a run in progress.
- Counter width is NBITS; a duration of 2^NBITS-1 must work without overflow.
- phase_onehot is a registered decode of phase and is valid on the same cycle as phase.
- Reset asserted mid-run: immediate IDLE, and the table reverts to defaults.

Test Plan:
- Defaults, n_cycles=1, start: phase strobes after 0, 20000, 70000, 60070000 cycles, etc. → done exactly 96830000 cycles after the first strobe; cycle_count=1.
- Table set to 3,0,2,1,0,0,0,0,0,4, n_cycles=2 → phase sequence 0,0,0,2,2,3,9,9,9,9 repeated twice. cycle_done pulses twice and done once; busy is high for 20 cycles; phases 1 and 4–8 never appear.
- n_cycles=0 with table all 1 → phase increments every cycle and wraps 9→0 with no gap. cycle_count reaches 5 after 50 cycles; abort at cycle 50 → aborted=1, done=0, busy=0 next cycle.
- Config write while busy and a write with cfg_addr=12 → cfg_err pulse each, table unchanged (read back via phase durations). Start with an all-zero table → cfg_err and stay IDLE.
- Same-cycle events: start+abort in IDLE → no run. abort on the final cycle of the last pass → aborted=1, done=0.
- Async reset mid-run (reset low between edges) → all outputs 0 immediately. The next start uses the default 20000-cycle first phase.

Source files
------------

// File: rtl/seq_scheduler.sv
// seq_scheduler: programmable 10-phase timing sequencer.
// A per-phase duration table, written over a simple config port, drives a
// down-counter that steps through the nonzero phases for n_cycles passes,
// or forever when n_cycles is 0, under start/abort control.
// Ports:
//   clk, reset (async, active-low)
//   start, abort, n_cycles            run control
//   cfg_we, cfg_addr, cfg_data        duration table writes (IDLE only)
//   busy, phase, phase_onehot         run status
//   phase_strobe, cycle_done, done,
//   aborted, cfg_err                  one-cycle event pulses
//   cycle_count                       completed passes in current/last run
module seq_scheduler #(
    parameter int unsigned NBITS = 27,
    parameter int unsigned NPH   = 10,
    parameter int unsigned CBITS = 16,
    parameter int unsigned D0    = 20000,
    parameter int unsigned D1    = 50000,
    parameter int unsigned D2    = 60000000,
    parameter int unsigned D3    = 250000,
    parameter int unsigned D4    = 30000000,
    parameter int unsigned D5    = 630000,
    parameter int unsigned D6    = 1840000,
    parameter int unsigned D7    = 1890000,
    parameter int unsigned D8    = 950000,
    parameter int unsigned D9    = 1200000
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             abort,
    input  logic [CBITS-1:0] n_cycles,
    input  logic             cfg_we,
    input  logic [3:0]       cfg_addr,
    input  logic [NBITS-1:0] cfg_data,
    output logic             busy,
    output logic [3:0]       phase,
    output logic [NPH-1:0]   phase_onehot,
    output logic             phase_strobe,
    output logic             cycle_done,
    output logic             done,
    output logic             aborted,
    output logic [CBITS-1:0] cycle_count,
    output logic             cfg_err
);
    localparam int unsigned PW = 4;

    typedef enum logic {S_IDLE = 1'b0, S_RUN = 1'b1} state_e;

    state_e           state_q, state_d;
    logic [NBITS-1:0] dur_q [NPH];
    logic [NBITS-1:0] dur_d [NPH];
    logic [PW-1:0]    phase_q, phase_d;
    logic [NPH-1:0]   onehot_q, onehot_d;
    logic [NBITS-1:0] cnt_q, cnt_d;
    logic [CBITS-1:0] ncyc_q, ncyc_d;
    logic [CBITS-1:0] count_q, count_d;
    logic             strobe_q, strobe_d;
    logic             cdone_q, cdone_d;
    logic             done_q, done_d;
    logic             aborted_q, aborted_d;
    logic             cfg_err_q, cfg_err_d;

    logic             any_nz, next_found;
    logic [PW-1:0]    first_idx, last_idx, next_idx;
    logic [NBITS-1:0] first_dur, next_dur;
    logic             start_go, wr_ok;

    function automatic logic [NBITS-1:0] default_dur(input int unsigned k);
        case (k)
            0:       default_dur = NBITS'(D0);
            1:       default_dur = NBITS'(D1);
            2:       default_dur = NBITS'(D2);
            3:       default_dur = NBITS'(D3);
            4:       default_dur = NBITS'(D4);
            5:       default_dur = NBITS'(D5);
            6:       default_dur = NBITS'(D6);
            7:       default_dur = NBITS'(D7);
            8:       default_dur = NBITS'(D8);
            default: default_dur = NBITS'(D9);
        endcase
    endfunction

    // Table scan: first/last nonzero phase and the next nonzero phase above phase_q.
    always_comb begin
        any_nz     = 1'b0;
        next_found = 1'b0;
        first_idx  = '0;
        last_idx   = '0;
        next_idx   = '0;
        first_dur  = '0;
        next_dur   = '0;
        for (int unsigned k = 0; k < NPH; k++) begin
            if (dur_q[k] != '0) begin
                if (!any_nz) begin
                    first_idx = PW'(k);
                    first_dur = dur_q[k];
                end
                last_idx = PW'(k);
                any_nz   = 1'b1;
                if (!next_found && (PW'(k) > phase_q)) begin
                    next_idx   = PW'(k);
                    next_dur   = dur_q[k];
                    next_found = 1'b1;
                end
            end
        end
    end

    // A write landing on the same edge as an accepted start is dropped so the
    // run never sees a table that differs from the one it started with.
    always_comb begin
        start_go = (state_q == S_IDLE) && start && !abort && any_nz;
        wr_ok    = cfg_we && (state_q == S_IDLE) && !start_go && (cfg_addr < PW'(NPH));
        dur_d    = dur_q;
        for (int unsigned k = 0; k < NPH; k++) begin
            if (wr_ok && (cfg_addr == PW'(k))) begin
                dur_d[k] = cfg_data;
            end
        end
    end

    // Next-state and registered-output logic.
    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        cnt_d     = cnt_q;
        ncyc_d    = ncyc_q;
        count_d   = count_q;
        strobe_d  = 1'b0;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        cfg_err_d = cfg_we && !wr_ok;

        case (state_q)
            S_IDLE: begin
                if (start && !abort) begin
                    if (any_nz) begin
                        state_d  = S_RUN;
                        phase_d  = first_idx;
                        cnt_d    = first_dur - NBITS'(1);
                        strobe_d = 1'b1;
                        count_d  = '0;
                        ncyc_d   = n_cycles;
                    end else begin
                        cfg_err_d = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (abort) begin
                    state_d   = S_IDLE;
                    aborted_d = 1'b1;
                end else if (cnt_q == '0) begin
                    if (next_found) begin
                        phase_d  = next_idx;
                        cnt_d    = next_dur - NBITS'(1);
                        strobe_d = 1'b1;
                    end else if ((ncyc_q != '0) && (count_q == ncyc_q)) begin
                        state_d = S_IDLE;
                        done_d  = 1'b1;
                    end else begin
                        phase_d  = first_idx;
                        cnt_d    = first_dur - NBITS'(1);
                        strobe_d = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - NBITS'(1);
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (state_d == S_IDLE) begin
            phase_d = '0;
            cnt_d   = '0;
        end

        // Flag the last cycle of a pass one edge early so it lands on that cycle.
        cdone_d = (state_d == S_RUN) && (cnt_d == '0) && (phase_d == last_idx);
        if (cdone_d && (count_d != '1)) begin
            count_d = count_d + CBITS'(1);
        end

        onehot_d = (state_d == S_RUN) ? (NPH'(1) << phase_d) : '0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            for (int unsigned k = 0; k < NPH; k++) begin
                dur_q[k] <= default_dur(k);
            end
            phase_q   <= '0;
            onehot_q  <= '0;
            cnt_q     <= '0;
            ncyc_q    <= '0;
            count_q   <= '0;
            strobe_q  <= 1'b0;
            cdone_q   <= 1'b0;
            done_q    <= 1'b0;
            aborted_q <= 1'b0;
            cfg_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            dur_q     <= dur_d;
            phase_q   <= phase_d;
            onehot_q  <= onehot_d;
            cnt_q     <= cnt_d;
            ncyc_q    <= ncyc_d;
            count_q   <= count_d;
            strobe_q  <= strobe_d;
            cdone_q   <= cdone_d;
            done_q    <= done_d;
            aborted_q <= aborted_d;
            cfg_err_q <= cfg_err_d;
        end
    end

    assign busy         = (state_q == S_RUN);
    assign phase        = phase_q;
    assign phase_onehot = onehot_q;
    assign phase_strobe = strobe_q;
    assign cycle_done   = cdone_q;
    assign done         = done_q;
    assign aborted      = aborted_q;
    assign cycle_count  = count_q;
    assign cfg_err      = cfg_err_q;

endmodule

// File: tb/tb_seq_scheduler.sv
// Scoreboard bench for seq_scheduler: stimulus pushes expected events
// (kind, phase, cycle, count); a negedge monitor pops and compares them.
module tb_seq_scheduler;
    localparam int unsigned NBITS = 27;
    localparam int unsigned NPH   = 10;
    localparam int unsigned CBITS = 16;

    localparam int K_STROBE = 0;
    localparam int K_CDONE  = 1;
    localparam int K_DONE   = 2;
    localparam int K_ABORT  = 3;
    localparam int K_CERR   = 4;

    typedef struct {
        int kind;
        int ph;
        int at;
        int cnt;
    } evt_t;

    logic             clk = 1'b0;
    logic             reset;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [CBITS-1:0] n_cycles = '0;
    logic             cfg_we = 1'b0;
    logic [3:0]       cfg_addr = '0;
    logic [NBITS-1:0] cfg_data = '0;
    logic             busy;
    logic [3:0]       phase;
    logic [NPH-1:0]   phase_onehot;
    logic             phase_strobe;
    logic             cycle_done;
    logic             done;
    logic             aborted;
    logic [CBITS-1:0] cycle_count;
    logic             cfg_err;

    seq_scheduler dut (
        .clk          (clk),
        .reset        (reset),
        .start        (start),
        .abort        (abort),
        .n_cycles     (n_cycles),
        .cfg_we       (cfg_we),
        .cfg_addr     (cfg_addr),
        .cfg_data     (cfg_data),
        .busy         (busy),
        .phase        (phase),
        .phase_onehot (phase_onehot),
        .phase_strobe (phase_strobe),
        .cycle_done   (cycle_done),
        .done         (done),
        .aborted      (aborted),
        .cycle_count  (cycle_count),
        .cfg_err      (cfg_err)
    );

    always #5 clk = ~clk;

    int   cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    evt_t sb[$];
    int   checks = 0;
    int   failures = 0;
    int   busy_cycles = 0;
    int   seen[NPH];

    function automatic string kname(input int k);
        case (k)
            K_STROBE: kname = "phase_strobe";
            K_CDONE:  kname = "cycle_done";
            K_DONE:   kname = "done";
            K_ABORT:  kname = "aborted";
            default:  kname = "cfg_err";
        endcase
    endfunction

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cyc %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic push(input int kind, input int ph, input int at, input int cnt);
        evt_t e;
        e.kind = kind;
        e.ph   = ph;
        e.at   = at;
        e.cnt  = cnt;
        sb.push_back(e);
    endtask

    // Pop the oldest expected event of this kind and compare it with the DUT.
    task automatic check_evt(input int kind);
        int   idx;
        bit   ok;
        evt_t e;
        idx = -1;
        for (int i = 0; i < sb.size(); i++) begin
            if (idx < 0 && sb[i].kind == kind) idx = i;
        end
        checks++;
        if (idx < 0) begin
            failures++;
            $display("FAIL unexpected_%s: phase %0d count %0d at cyc %0d, none expected",
                     kname(kind), phase, cycle_count, cyc);
        end else begin
            e = sb[idx];
            sb.delete(idx);
            ok = (cyc == e.at);
            if (kind == K_STROBE)
                ok = ok && (int'(phase) == e.ph) && (phase_onehot == (NPH'(1) << e.ph)) && busy;
            if (kind == K_CDONE || kind == K_DONE || kind == K_ABORT)
                ok = ok && (int'(cycle_count) == e.cnt);
            if (!ok) begin
                failures++;
                $display("FAIL %s: got cyc %0d phase %0d onehot %b count %0d busy %0b, expected cyc %0d phase %0d count %0d",
                         kname(kind), cyc, phase, phase_onehot, cycle_count, busy, e.at, e.ph, e.cnt);
            end
        end
    endtask

    always @(negedge clk) begin
        if (busy) begin
            busy_cycles++;
            for (int k = 0; k < NPH; k++) if (phase_onehot[k]) seen[k]++;
        end
        if (phase_strobe) check_evt(K_STROBE);
        if (cycle_done)   check_evt(K_CDONE);
        if (done)         check_evt(K_DONE);
        if (aborted)      check_evt(K_ABORT);
        if (cfg_err)      check_evt(K_CERR);
    end

    task automatic cfg_write(input int a, input int d);
        cfg_we   = 1'b1;
        cfg_addr = 4'(a);
        cfg_data = NBITS'(d);
        @(negedge clk);
        cfg_we = 1'b0;
    endtask

    task automatic load(input int vals[NPH]);
        for (int k = 0; k < NPH; k++) cfg_write(k, vals[k]);
    endtask

    task automatic do_start(input int n);
        start    = 1'b1;
        n_cycles = CBITS'(n);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_until(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    // Reference model of one pass: strobes at each nonzero phase, cycle_done on its last cycle.
    task automatic push_pass(input int vals[NPH], input int p, inout int t);
        for (int k = 0; k < NPH; k++) begin
            if (vals[k] != 0) begin
                push(K_STROBE, k, t, 0);
                t += vals[k];
            end
        end
        push(K_CDONE, 0, t - 1, p + 1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int tb_b[NPH]   = '{3, 0, 2, 1, 0, 0, 0, 0, 0, 4};
        int ones[NPH]   = '{1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
        int zeros[NPH]  = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        int exp_b[NPH]  = '{6, 0, 4, 2, 0, 0, 0, 0, 0, 8};
        int base[NPH];
        int bc0;
        int c0;
        int t;

        for (int k = 0; k < NPH; k++) seen[k] = 0;
        reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("reset_busy", longint'(busy), 0);
        chk("reset_phase", longint'(phase), 0);
        chk("reset_onehot", longint'(phase_onehot), 0);
        chk("reset_count", longint'(cycle_count), 0);
        reset = 1'b1;
        @(negedge clk);
        chk("idle_busy", longint'(busy), 0);
        chk("idle_pulses", longint'({phase_strobe, cycle_done, done, aborted, cfg_err}), 0);

        // Sparse table, two passes.
        load(tb_b);
        base = seen;
        bc0  = busy_cycles;
        c0   = cyc;
        t    = c0 + 1;
        for (int p = 0; p < 2; p++) push_pass(tb_b, p, t);
        push(K_DONE, 0, t, 2);
        do_start(2);
        wait_until(c0 + 25);
        chk("b_busy_cycles", longint'(busy_cycles - bc0), 20);
        for (int k = 0; k < NPH; k++) chk($sformatf("b_phase%0d_cycles", k), longint'(seen[k] - base[k]), longint'(exp_b[k]));
        chk("b_count_after", longint'(cycle_count), 2);

        // Continuous all-ones run with a rejected write mid-run, then abort after 50 cycles.
        load(ones);
        c0 = cyc;
        t  = c0 + 1;
        for (int p = 0; p < 5; p++) push_pass(ones, p, t);
        do_start(0);
        wait_until(c0 + 20);
        push(K_CERR, 0, cyc + 1, 0);
        cfg_write(0, 7);
        wait_until(c0 + 50);
        push(K_ABORT, 0, c0 + 51, 5);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("c_busy_after_abort", longint'(busy), 0);
        chk("c_done_after_abort", longint'(done), 0);
        chk("c_count_held", longint'(cycle_count), 5);

        // Out-of-range address in IDLE.
        push(K_CERR, 0, cyc + 1, 0);
        cfg_write(12, 5);

        // Abort on the final cycle of the last pass; table must still be all ones.
        c0 = cyc;
        t  = c0 + 1;
        push_pass(ones, 0, t);
        push(K_ABORT, 0, c0 + 11, 1);
        do_start(1);
        wait_until(c0 + 10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("e_busy_after_abort", longint'(busy), 0);

        // start together with abort in IDLE: no run.
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        @(negedge clk);
        chk("start_abort_busy", longint'(busy), 0);

        // Start with an all-zero table.
        load(zeros);
        push(K_CERR, 0, cyc + 1, 0);
        do_start(1);
        @(negedge clk);
        chk("zero_table_busy", longint'(busy), 0);
        chk("zero_table_phase", longint'(phase), 0);

        // Async reset mid-run, then the defaults are back.
        load(ones);
        c0 = cyc;
        for (int k = 0; k < 5; k++) push(K_STROBE, k, c0 + 1 + k, 0);
        do_start(0);
        wait_until(c0 + 5);
        #2 reset = 1'b0;
        #1;
        chk("rst_busy", longint'(busy), 0);
        chk("rst_phase", longint'(phase), 0);
        chk("rst_onehot", longint'(phase_onehot), 0);
        chk("rst_strobe", longint'(phase_strobe), 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        c0 = cyc;
        push(K_STROBE, 0, c0 + 1, 0);
        push(K_STROBE, 1, c0 + 20001, 0);
        do_start(1);
        wait_until(c0 + 20003);
        push(K_ABORT, 0, c0 + 20004, 0);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("def_busy_after_abort", longint'(busy), 0);

        for (int i = 0; i < 20 && sb.size() != 0; i++) @(negedge clk);
        chk("scoreboard_empty", longint'(sb.size()), 0);
        foreach (sb[i]) $display("FAIL missing_%s: expected at cyc %0d phase %0d", kname(sb[i].kind), sb[i].at, sb[i].ph);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
